salsa_stream_ctrl: RTL and testbench

//  Sequencer in front of the salsa keystream core. Takes one job (key, nonce, start counter, word count) on a

---
 rtl/salsa_ctrl_pkg.sv | 23 ++
 rtl/salsa_word_fifo.sv | 52 +++++
 rtl/salsa_stream_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_salsa_stream_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/salsa_ctrl_pkg.sv
// salsa_ctrl_pkg: shared widths and FSM encoding for the salsa stream
// sequencer and its output word buffer.
package salsa_ctrl_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int KEY_W           = 256;
    localparam int WORD_W          = 128;
    localparam int CNT_W           = 64;
    localparam int NONCE_W         = 64;
    localparam int BLK_IDX_W       = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [2:0] {
        IDLE,
        SETKEY,
        SETGAP,
        SETCNT,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        DRAIN
    } state_t;

endpackage

// File: rtl/salsa_word_fifo.sv
// salsa_word_fifo: synchronous FIFO of {last, data} words; the count output
// lets the sequencer hold back core starts when no slot is free.
module salsa_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 129
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign rdata  = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the reader masks it while empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wdata;
    end

endmodule

// File: rtl/salsa_stream_ctrl.sv
// salsa_stream_ctrl: job sequencer in front of the salsa keystream core.
// Define SALSA_CTRL_XOR_EN to add the PT_* plaintext port and XOR output.
module salsa_stream_ctrl
    import salsa_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NW_W       = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CFG_VALID,
    output logic                CFG_READY,
    input  logic [KEY_W-1:0]    CFG_KEY,
    input  logic [NONCE_W-1:0]  CFG_NONCE,
    input  logic [CNT_W-1:0]    CFG_COUNTER,
    input  logic [NW_W-1:0]     CFG_NWORDS,
    output logic                KS_VALID,
    input  logic                KS_READY,
    output logic [WORD_W-1:0]   KS_DATA,
    output logic                KS_LAST,
`ifdef SALSA_CTRL_XOR_EN
    input  logic                PT_VALID,
    output logic                PT_READY,
    input  logic [WORD_W-1:0]   PT_DATA,
`endif
    output logic                DONE,
    output logic                BUSY,
    output logic [CNT_W-1:0]    COUNTER_NEXT,
    output logic                CORE_SET_KEY,
    output logic                CORE_SET_COUNT,
    output logic                CORE_START_ENC,
    output logic [WORD_W-1:0]   CORE_DATA_IN,
    output logic [KEY_W-1:0]    CORE_KEY_IN,
    input  logic                CORE_BUSY,
    input  logic [WORD_W-1:0]   CORE_DATA_OUT
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t               state;
    state_t               state_nx;
    logic [KEY_W-1:0]     key_q;
    logic [NONCE_W-1:0]   nonce_q;
    logic [NW_W-1:0]      nwords_q;
    logic [NW_W-1:0]      issued;
    logic [NW_W-1:0]      pushed;
    logic [CNT_W-1:0]     blk;
    logic [CNT_W-1:0]     cnt_next;
    logic                 done_q;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 start;
    logic                 empty;
    logic                 inflight;
    logic                 has_credit;
    logic                 blk_first;
    logic                 blk_final;
    logic [CW-1:0]        count;
    logic [WORD_W:0]      head;

    assign CFG_READY   = (state == IDLE);
    assign BUSY        = !CFG_READY;
    assign accept      = CFG_VALID && CFG_READY;
    assign inflight    = (state == WAIT_HI) || (state == WAIT_LO);
    assign has_credit  = (count + CW'(inflight)) < CW'(FIFO_DEPTH);
    assign blk_first   = (pushed[BLK_IDX_W-1:0] == '0);
    assign blk_final   = (pushed[BLK_IDX_W-1:0] == BLK_IDX_W'(WORDS_PER_BLOCK - 1));

    assign DONE           = done_q;
    assign COUNTER_NEXT   = cnt_next;
    assign CORE_START_ENC = start;
    assign CORE_DATA_IN   = {blk, nonce_q};
    assign CORE_KEY_IN    = key_q;

    always_comb begin
        state_nx       = state;
        CORE_SET_KEY   = 1'b0;
        CORE_SET_COUNT = 1'b0;
        start          = 1'b0;
        push           = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && CFG_NWORDS != '0)
                    state_nx = SETKEY;
            end
            SETKEY: begin
                if (!CORE_BUSY) begin
                    CORE_SET_KEY = 1'b1;
                    state_nx     = SETGAP;
                end
            end
            // Give the core a cycle to raise BUSY after SET_KEY.
            SETGAP: state_nx = SETCNT;
            SETCNT: begin
                if (!CORE_BUSY) begin
                    CORE_SET_COUNT = 1'b1;
                    state_nx       = ISSUE;
                end
            end
            ISSUE: begin
                if (issued == nwords_q) begin
                    state_nx = DRAIN;
                end else if (!CORE_BUSY && has_credit) begin
                    start    = 1'b1;
                    state_nx = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (CORE_BUSY)
                    state_nx = WAIT_LO;
            end
            WAIT_LO: begin
                if (!CORE_BUSY) begin
                    push     = 1'b1;
                    state_nx = ISSUE;
                end
            end
            DRAIN: begin
                if (empty)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            key_q    <= '0;
            nonce_q  <= '0;
            nwords_q <= '0;
            issued   <= '0;
            pushed   <= '0;
            blk      <= '0;
            cnt_next <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= (accept && CFG_NWORDS == '0) ||
                      (state == DRAIN && empty);
            if (accept) begin
                key_q    <= CFG_KEY;
                nonce_q  <= CFG_NONCE;
                nwords_q <= CFG_NWORDS;
                issued   <= '0;
                pushed   <= '0;
                blk      <= CFG_COUNTER;
                cnt_next <= CFG_COUNTER;
            end
            if (start)
                issued <= issued + 1'b1;
            // blk feeds the core; cnt_next rounds up to whole blocks.
            if (push) begin
                pushed <= pushed + 1'b1;
                if (blk_final)
                    blk <= blk + 1'b1;
                if (blk_first)
                    cnt_next <= blk + 1'b1;
            end
        end
    end

    salsa_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W + 1)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .wdata ({issued == nwords_q, CORE_DATA_OUT}),
        .rdata (head),
        .empty (empty),
        .count (count)
    );

    assign KS_VALID = !empty;
    assign KS_LAST  = KS_VALID && head[WORD_W];

`ifdef SALSA_CTRL_XOR_EN
    assign pop      = KS_VALID && KS_READY && PT_VALID;
    assign PT_READY = KS_VALID && KS_READY;
    assign KS_DATA  = KS_VALID ? (head[WORD_W-1:0] ^ PT_DATA) : '0;
`else
    assign pop      = KS_VALID && KS_READY;
    assign KS_DATA  = KS_VALID ? head[WORD_W-1:0] : '0;
`endif

endmodule

// File: tb/tb_salsa_stream_ctrl.sv
// tb_salsa_stream_ctrl: table-driven and randomized checks of the sequencer
// against a behavioural core model and a keystream scoreboard.
module tb_salsa_stream_ctrl;

    localparam int DEPTH = 4;

    typedef struct {
        logic [255:0] key;
        logic [63:0]  nonce;
        logic [63:0]  ctr;
        int           nwords;
        int           stall;
        logic [63:0]  exp_cnext;
    } vec_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         CFG_VALID = 1'b0;
    logic         CFG_READY;
    logic [255:0] CFG_KEY = '0;
    logic [63:0]  CFG_NONCE = '0;
    logic [63:0]  CFG_COUNTER = '0;
    logic [31:0]  CFG_NWORDS = '0;
    logic         KS_VALID;
    logic         KS_READY = 1'b0;
    logic [127:0] KS_DATA;
    logic         KS_LAST;
    logic         DONE;
    logic         BUSY;
    logic [63:0]  COUNTER_NEXT;
    logic         CORE_SET_KEY;
    logic         CORE_SET_COUNT;
    logic         CORE_START_ENC;
    logic [127:0] CORE_DATA_IN;
    logic [255:0] CORE_KEY_IN;
    logic         CORE_BUSY = 1'b0;
    logic [127:0] CORE_DATA_OUT = '0;
`ifdef SALSA_CTRL_XOR_EN
    logic         PT_VALID = 1'b1;
    logic         PT_READY;
    logic [127:0] PT_DATA = '1;
`endif

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int setkey_cnt = 0;
    int setcnt_cnt = 0;
    int done_cnt = 0;
    int pop_cnt = 0;
    int held = 0;
    logic [128:0] exp_q [$];

    always #5 CLK = ~CLK;

    salsa_stream_ctrl #(.FIFO_DEPTH(DEPTH), .NW_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
        .CFG_KEY(CFG_KEY), .CFG_NONCE(CFG_NONCE),
        .CFG_COUNTER(CFG_COUNTER), .CFG_NWORDS(CFG_NWORDS),
        .KS_VALID(KS_VALID), .KS_READY(KS_READY),
        .KS_DATA(KS_DATA), .KS_LAST(KS_LAST),
`ifdef SALSA_CTRL_XOR_EN
        .PT_VALID(PT_VALID), .PT_READY(PT_READY), .PT_DATA(PT_DATA),
`endif
        .DONE(DONE), .BUSY(BUSY), .COUNTER_NEXT(COUNTER_NEXT),
        .CORE_SET_KEY(CORE_SET_KEY), .CORE_SET_COUNT(CORE_SET_COUNT),
        .CORE_START_ENC(CORE_START_ENC), .CORE_DATA_IN(CORE_DATA_IN),
        .CORE_KEY_IN(CORE_KEY_IN), .CORE_BUSY(CORE_BUSY),
        .CORE_DATA_OUT(CORE_DATA_OUT)
    );

    function automatic void chk(input string nm, input logic [255:0] act,
                                input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    // Stand-in keystream: any keyed mix of (key, counter, nonce, word).
    function automatic logic [127:0] ks_word(input logic [255:0] k,
                                             input logic [63:0] c,
                                             input logic [63:0] n,
                                             input int w);
        logic [63:0] a;
        logic [63:0] b;
        a = k[63:0] ^ k[191:128] ^ (c * 64'h9E3779B97F4A7C15) ^ 64'(w * 32'h01000193);
        b = (k[127:64] ^ k[255:192] ^ (n * 64'hC2B2AE3D27D4EB4F)) + c + 64'(w);
        a = a ^ {a[40:0], a[63:41]} ^ b;
        b = b + {b[50:0], b[63:51]} + a;
        return {a, b};
    endfunction

    // Core model: busy for a random number of cycles per command.
    int           core_left = 0;
    int           core_idx = 0;
    logic         core_enc = 1'b0;
    logic [255:0] core_key = '0;
    logic [127:0] core_pend = '0;

    always @(posedge CLK) begin
        if (core_left > 0) begin
            core_left <= core_left - 1;
            if (core_left == 1) begin
                CORE_BUSY <= 1'b0;
                if (core_enc)
                    CORE_DATA_OUT <= core_pend;
            end
        end else if (CORE_SET_KEY || CORE_SET_COUNT || CORE_START_ENC) begin
            CORE_BUSY <= 1'b1;
            core_left <= int'($urandom_range(1, 4));
            core_enc  <= CORE_START_ENC;
            if (CORE_SET_KEY)
                core_key <= CORE_KEY_IN;
            if (CORE_SET_COUNT)
                core_idx <= 0;
            if (CORE_START_ENC) begin
                core_pend <= ks_word(core_key, CORE_DATA_IN[127:64],
                                     CORE_DATA_IN[63:0], core_idx % 4);
                core_idx  <= core_idx + 1;
            end
        end
    end

    // Scoreboard and protocol monitor, sampled mid-cycle.
    logic         hs;
    logic [127:0] xmask;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    logic         prev_last = 1'b0;
    logic [128:0] e;

`ifdef SALSA_CTRL_XOR_EN
    assign hs    = KS_VALID && KS_READY && PT_VALID;
    assign xmask = PT_DATA;
`else
    assign hs    = KS_VALID && KS_READY;
    assign xmask = '0;
`endif

    always @(negedge CLK) begin
        if (RST) begin
            held       = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 256'(KS_VALID), 256'(1));
                chk("hold_data", 256'(KS_DATA), 256'(prev_data));
                chk("hold_last", 256'(KS_LAST), 256'(prev_last));
            end
`ifdef SALSA_CTRL_XOR_EN
            chk("pt_ready", 256'(PT_READY), 256'(KS_VALID && KS_READY));
`endif
            if (CORE_START_ENC) begin
                chk("credit", 256'(held < DEPTH), 256'(1));
                start_cnt++;
                held++;
            end
            if (CORE_SET_KEY)
                setkey_cnt++;
            if (CORE_SET_COUNT)
                setcnt_cnt++;
            if (DONE)
                done_cnt++;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 256'(1), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("ks_data", 256'(KS_DATA), 256'(e[127:0] ^ xmask));
                    chk("ks_last", 256'(KS_LAST), 256'(e[128]));
                end
                pop_cnt++;
                held--;
            end
            prev_stall = KS_VALID && !hs;
            prev_data  = KS_DATA;
            prev_last  = KS_LAST;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_cfg_ready"}, 256'(CFG_READY), 256'(1));
        chk({nm, "_ks_valid"}, 256'(KS_VALID), 256'(0));
        chk({nm, "_ks_data"}, 256'(KS_DATA), 256'(0));
        chk({nm, "_ks_last"}, 256'(KS_LAST), 256'(0));
        chk({nm, "_done"}, 256'(DONE), 256'(0));
        chk({nm, "_busy"}, 256'(BUSY), 256'(0));
        chk({nm, "_cnext"}, 256'(COUNTER_NEXT), 256'(0));
        chk({nm, "_pulses"}, 256'({CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC}), 256'(0));
        chk({nm, "_core_din"}, 256'(CORE_DATA_IN), 256'(0));
        chk({nm, "_core_key"}, CORE_KEY_IN, 256'(0));
    endtask

    task automatic accept_job(input vec_t v);
        for (int i = 0; i < 50 && !CFG_READY; i++)
            tick();
        chk("cfg_ready_wait", 256'(CFG_READY), 256'(1));
        for (int i = 0; i < v.nwords; i++)
            exp_q.push_back({i == v.nwords - 1,
                             ks_word(v.key, v.ctr + 64'(i / 4), v.nonce, i % 4)});
        CFG_KEY     = v.key;
        CFG_NONCE   = v.nonce;
        CFG_COUNTER = v.ctr;
        CFG_NWORDS  = 32'(v.nwords);
        CFG_VALID   = 1'b1;
        tick();
        CFG_VALID   = 1'b0;
    endtask

    task automatic run_job(input vec_t v, input string nm);
        int  d0;
        int  p0;
        int  w0;
        int  budget;
        bit  got;
        d0     = done_cnt;
        p0     = setkey_cnt + setcnt_cnt + start_cnt;
        w0     = pop_cnt;
        budget = 300 + v.stall + v.nwords * 40;
        KS_READY = 1'b0;
        accept_job(v);
        if (v.nwords == 0)
            chk({nm, "_done_next"}, 256'(DONE), 256'(1));
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            KS_READY  = (c >= v.stall) && ($urandom_range(0, 3) != 0);
`ifdef SALSA_CTRL_XOR_EN
            PT_VALID  = ($urandom_range(0, 3) != 0);
`endif
            CFG_VALID = (v.nwords > 8 && c == 10);
            if (CFG_VALID) begin
                CFG_NWORDS = '0;
                chk({nm, "_cfg_ignored"}, 256'(CFG_READY), 256'(0));
            end
            if (DONE)
                got = 1'b1;
            else
                tick();
        end
        CFG_VALID = 1'b0;
        chk({nm, "_done_seen"}, 256'(got), 256'(1));
        if (!got) begin
            KS_READY = 1'b0;
            RST = 1'b1;
            tick();
            RST = 1'b0;
            exp_q.delete();
        end
        repeat (3) tick();
        KS_READY = 1'b0;
        chk({nm, "_done_once"}, 256'(done_cnt - d0), 256'(1));
        chk({nm, "_words"}, 256'(pop_cnt - w0), 256'(v.nwords));
        chk({nm, "_left"}, 256'(exp_q.size()), 256'(0));
        chk({nm, "_cnext"}, 256'(COUNTER_NEXT), 256'(v.exp_cnext));
        chk({nm, "_idle"}, 256'(CFG_READY), 256'(1));
        if (v.nwords == 0)
            chk({nm, "_no_pulse"}, 256'(setkey_cnt + setcnt_cnt + start_cnt - p0), 256'(0));
    endtask

    vec_t vecs [6];
    vec_t rv;

    initial begin : main
        logic [255:0] k;
        logic [63:0]  n;
        int           s0;
        k = {4{64'h1234567890ABCDEF}};
        n = 64'h1234567890ABCDEF;
        vecs[0] = '{k, n, 64'h0, 4, 0, 64'h1};
        vecs[1] = '{k, n, 64'h0, 16, 60, 64'h4};
        vecs[2] = '{k, n, 64'h77, 0, 0, 64'h77};
        vecs[3] = '{k, n, 64'hFFFF_FFFF_FFFF_FFFF, 8, 5, 64'h1};
        vecs[4] = '{~k, 64'hDEAD_BEEF_0000_0001, 64'h5, 5, 3, 64'h7};
        vecs[5] = '{k ^ 256'h55, n, 64'h10, 1, 0, 64'h11};

        repeat (3) tick();
        check_idle_outputs("reset");
        RST = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_job(vecs[i], $sformatf("vec%0d", i));

        // Abort a 16-word job around its third word.
        rv = vecs[1];
        rv.stall = 0;
        accept_job(rv);
        s0 = start_cnt;
        for (int c = 0; c < 400 && start_cnt - s0 < 3; c++) begin
            KS_READY = ($urandom_range(0, 1) != 0);
            tick();
        end
        chk("abort_reached", 256'(start_cnt - s0 >= 3), 256'(1));
        tick();
        KS_READY = 1'b0;
        RST = 1'b1;
        tick();
        check_idle_outputs("abort");
        RST = 1'b0;
        exp_q.delete();
        run_job(vecs[0], "after_abort");

        for (int r = 0; r < 6; r++) begin
            rv.key    = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
            rv.nonce  = {$urandom, $urandom};
            rv.ctr    = (r == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom};
            rv.nwords = int'($urandom_range(1, 10));
            rv.stall  = int'($urandom_range(0, 20));
            rv.exp_cnext = rv.ctr + 64'((rv.nwords + 3) / 4);
            run_job(rv, $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
